xor_rr_sequencer: RTL
=====================

// Module: xor_rr_sequencer
// PURPOSE
//  Shares one 1-bit Xor gate instance between N_REQ requesters, each submitting a W-bit operand pair.
//  A round-robin arbiter picks one requester; the sequencer then streams the operand bits through the Xor gate, LSB first, one bit per cycle.
//  It returns the W-bit result with the winner's id over a valid/ready handshake.
//  Sits between the requesting blocks and the shared Xor datapath.
// PARAMETERS
//  N_REQ  4  number of requesters (>=2)
//  W      8  operand/result width in bits (>=1)
//  IDW    2  id width, = clog2(N_REQ)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        synchronous reset, active-low
//  req_valid  in   N_REQ    per-requester request valid
//  req_ready  out  N_REQ    one-hot accept strobe, combinational in IDLE
//  req_a      in   N_REQ*W  operand A, requester i at [i*W +: W]
//  req_b      in   N_REQ*W  operand B, same packing
//  rsp_valid  out  1        result valid
//  rsp_ready  in   1        consumer accepts result
//  rsp_data   out  W        A ^ B of the served request
//  rsp_id     out  IDW      index of the served requester
//  busy       out  1        high in any state other than IDLE
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low.
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE, ptr=0, cnt=0;
//   - all of req_ready, rsp_valid, rsp_data, rsp_id and busy read 0.
//  FSM:
//   - IDLE: if any req_valid, winner = first set index scanning ptr, ptr+1, ... (mod N_REQ).
//     req_ready[winner]=1 in that cycle only. Latch a, b and id; ptr <= (winner+1) mod N_REQ; cnt <= 0; go to RUN.
//     If no req_valid, stay in IDLE with req_ready=0.
//   - RUN: Xor.i0 = a_q[cnt], Xor.i1 = b_q[cnt]; res_q[cnt] <= Xor.out; cnt++.
//     At cnt==W-1, go to DONE. req_ready=0 throughout.
//   - DONE: rsp_valid=1; rsp_data=res_q and rsp_id=id_q, both held stable.
//     On rsp_valid & rsp_ready, go to IDLE. No new request is accepted while in DONE.
//  Latency: accept in cycle T, so rsp_valid is first high in cycle T+W+1.
//   Minimum interval between accepts is W+2 cycles (with rsp_ready tied 1).
//  Requester rule: a, b and valid are held stable until that requester's req_ready.
//   Deasserting req_valid before ready is legal; the requester is simply not picked.
//  Simultaneous requests: exactly one is granted per arbitration; the others wait. Fairness is strict round-robin.
//  Wrap: ptr and the winner scan wrap modulo N_REQ; cnt counts 0..W-1 and is cleared on each accept.
//  Reset mid-operation: the operation in flight is discarded; no rsp_valid is ever produced for it.
//   The next arbitration starts from ptr=0.
//  rsp_ready high outside DONE is ignored.
//  Width rules: res_q, a_q and b_q are W bits; cnt is clog2(W) bits (min 1); rsp_data bit k = a[k]^b[k].
// STRUCTURE
//  Shared package xor_seq_pkg:
//   - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//   - a clog2 function for the IDW and cnt widths.
//  Sub-module: exactly one instance of the existing 1-bit Xor gate (i0, i1, out), the shared datapath.
//  Arbiter pick logic stays inline: a rotate/priority-scan from ptr.
// TESTING (N_REQ=4, W=8)
//  1. Hold rst_n=0 for 2 cycles -> req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
//  2. req_valid=4'b0001, a0=8'hA5, b0=8'h0F -> req_ready=4'b0001 for 1 cycle.
//     rsp_valid follows 9 cycles later with rsp_data=8'hAA, rsp_id=0.
//  3. req_valid=4'b1111 held, rsp_ready=1 -> grants in order id 0,1,2,3,0, each W+2 cycles apart.
//  4. Drive rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_data and rsp_id stay stable; req_ready stays 0.
//     Then rsp_ready=1 -> IDLE on the next cycle.
//  5. Drop rst_n for 1 cycle at the 3rd RUN cycle of a request from id 2 -> that request never gets a rsp_valid.
//     A following req_valid=4'b0110 is granted id 1 (ptr back at 0).
//  6. Data corners: a=8'hFF,b=8'h00 -> 8'hFF; a=b=8'h3C -> 8'h00; a=8'h55,b=8'hAA -> 8'hFF.

Source files
------------

// File: rtl/xor_seq_pkg.sv
// Shared definitions for the round-robin Xor sequencer: FSM state encoding and a
// width helper for the id and bit-counter sizes.
package xor_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/xor_rr_sequencer_if.sv
// Request/response bundle between the requesters, the sequencer and the result consumer.
interface xor_rr_sequencer_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [W-1:0]       rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/xor_rr_sequencer_xor.sv
// The shared 1-bit Xor gate that every served request is streamed through.
module xor_gate (
  input  logic i0,
  input  logic i1,
  output logic out
);
  assign out = i0 ^ i1;
endmodule

// File: rtl/xor_rr_sequencer.sv
// Round-robin sequencer: grants one requester, streams its operand pair LSB first
// through the single shared Xor gate and returns the word result with the winner's id.
module xor_rr_sequencer
  import xor_seq_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = clog2(N_REQ)
) (
  input logic               clk,
  input logic               rst_n,
  xor_rr_sequencer_if.slave bus
);
  localparam int CW = (clog2(W) < 1) ? 1 : clog2(W);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [IDW-1:0] PTR_LAST = IDW'(N_REQ - 1);
  localparam logic [IDW-1:0] PTR_ONE  = IDW'(1);
  localparam logic [IDW:0]   N_EXT    = (IDW + 1)'(N_REQ);

  state_e         state_r;
  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] id_r;
  logic [CW-1:0]  cnt_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   res_r;
  logic           rsp_valid_r;
  logic           busy_r;

  logic           any_s;
  logic [IDW-1:0] win_s;
  logic [IDW-1:0] idx_s;
  logic [IDW:0]   sum_s;
  logic [N_REQ-1:0] grant_s;
  logic           xor_i0_s;
  logic           xor_i1_s;
  logic           xor_out_s;

  // Priority scan over the requesters starting at ptr, wrapping modulo N_REQ
  always_comb begin
    any_s = 1'b0;
    win_s = '0;
    sum_s = '0;
    idx_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s = {1'b0, ptr_r} + (IDW + 1)'(k);
      if (sum_s >= N_EXT) begin
        idx_s = IDW'(sum_s - N_EXT);
      end else begin
        idx_s = IDW'(sum_s);
      end
      if (!any_s && bus.req_valid[idx_s]) begin
        any_s = 1'b1;
        win_s = idx_s;
      end else begin
        any_s = any_s;
      end
    end
  end

  // Accept strobe is combinational so the winner sees it in the accepting cycle
  always_comb begin
    grant_s = '0;
    if (rst_n && (state_r == S_IDLE) && any_s) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign xor_i0_s = a_r[cnt_r];
  assign xor_i1_s = b_r[cnt_r];

  xor_gate u_xor (
    .i0  (xor_i0_s),
    .i1  (xor_i1_s),
    .out (xor_out_s)
  );

  // Sequencer FSM: accept, stream W bits through the gate, hold the result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      ptr_r       <= '0;
      id_r        <= '0;
      cnt_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (any_s) begin
            a_r     <= bus.req_a[win_s*W +: W];
            b_r     <= bus.req_b[win_s*W +: W];
            id_r    <= win_s;
            ptr_r   <= (win_s == PTR_LAST) ? '0 : win_s + PTR_ONE;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          res_r[cnt_r] <= xor_out_s;
          cnt_r        <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            rsp_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = res_r;
  assign bus.rsp_id    = id_r;
  assign bus.busy      = busy_r;

endmodule
